mano_core_p: RTL and testbench
==============================

Name: mano_core_p

Overview:
- Parametrised successor to the fixed 16-bit Mano basic computer.
- Word width is generic; memory is internal and word-addressed.
- Adds host program load/readback, a run/halt handshake, interrupt cycle and handshaked 8-bit I/O (FGI/FGO).
- Used as the CPU top; same debug outputs (Q_PC, Q_AR, Q_IR, Q_DR, AC, t) for benches.

Parameters:
- DATA_W, 16, word width; must be >=16. Derived localparam ADDR_W = DATA_W-4; memory depth 2^ADDR_W.
- INT_EN_RST, 0, reset value of IEN.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- RUN  in  1  1-cycle pulse; starts execution when halted
- HALTED  out  1  1 when S=0
- PRG_WE  in  1  host write M[PRG_ADDR]<=PRG_DATA; honoured only when HALTED
- PRG_ADDR  in  ADDR_W  host address
- PRG_DATA  in  DATA_W  host write data
- PRG_RDATA  out  DATA_W  combinational M[PRG_ADDR]
- IN_DATA  in  8  input character
- IN_VALID  in  1  input offered
- IN_READY  out  1  equals ~FGI
- OUT_DATA  out  8  OUTR
- OUT_VALID  out  1  equals ~FGO
- OUT_ACK  in  1  consumer took OUT_DATA
- Q_PC, Q_AR  out  ADDR_W  registers
- Q_IR, Q_DR, AC  out  DATA_W  registers
- E  out  1  carry flip-flop
- t  out  3  sequence counter SC

Behaviour:
- Reset (async): PC, AR, IR, DR, AC, TR, E, SC, OUTR = 0; S=0; R=0; IEN=INT_EN_RST; FGI=0; FGO=1. Memory is not reset.
- Memory access:
  - Read is combinational M[AR].
  - Writes are synchronous. A host write and a core write cannot both occur, because the host write is gated by HALTED.
- RUN when S=0 sets S=1 and SC=0; PC keeps its value. RUN while S=1 is ignored.
- While S=0, all CPU registers hold.
- Instruction fields: I = bit DATA_W-1; opcode = bits DATA_W-2..DATA_W-4; address = bits ADDR_W-1..0.
- Register-reference and I/O bits use positions 11..0, matching the 16-bit encoding.
- Fetch/decode (R=0):
  - T0: AR<=PC.
  - T1: IR<=M[AR]; PC<=PC+1.
  - T2: AR<=IR address field; latch I.
- T3:
  - Memory-reference with I=1: AR<=M[AR]. With I=0: no-op.
  - Opcode 7, I=0 (register-reference): executes CLA, CLE, CMA, CME, CIR, CIL, INC, SPA, SNA, SZA, SZE, HLT, then SC<=0.
  - Opcode 7, I=1 (I/O): executes INP, OUT, SKI, SKO, ION, IOF, then SC<=0.
  - Skip instructions: PC<=PC+1.
  - HLT: S<=0.
- Execute (SC<=0 on the last step of each):
  - AND/ADD/LDA: T4 DR<=M[AR]; T5 AC<=AC&DR, or E,AC<=AC+DR (DATA_W+1-bit sum), or AC<=DR.
  - STA: T4 M[AR]<=AC.
  - BUN: T4 PC<=AR.
  - BSA: T4 M[AR]<=PC (zero-extended), AR<=AR+1; T5 PC<=AR.
  - ISZ: T4 DR<=M[AR]; T5 DR<=DR+1; T6 M[AR]<=DR, and PC<=PC+1 if DR==0.
- Instruction lengths:
  - 6 cycles: AND, ADD, LDA, BSA.
  - 5 cycles: STA, BUN.
  - 7 cycles: ISZ.
  - 4 cycles: register-reference, I/O.
- Interrupt:
  - R<=1 when IEN & (FGI|FGO) & SC not in {0,1,2} & S.
  - Interrupt cycle replaces fetch when R=1 at T0.
  - RT0: AR<=0, TR<=PC.
  - RT1: M[0]<=TR, PC<=0.
  - RT2: PC<=PC+1, IEN<=0, R<=0, SC<=0.
- I/O handshake:
  - IN_VALID & ~FGI: INPR<=IN_DATA, FGI<=1.
  - INP: AC[7:0]<=INPR, FGI<=0.
  - OUT: OUTR<=AC[7:0], FGO<=0.
  - OUT_ACK & ~FGO: FGO<=1.
  - Same-cycle conflicts: an instruction clearing a flag has priority over an external event setting it.
- Wrap-around: PC and AR increment modulo 2^ADDR_W; AC arithmetic is modulo 2^DATA_W with carry into E.
- Reset asserted mid-instruction aborts immediately to the reset state. Memory contents are preserved.

Test Plan:
- Load 000:2010, 001:1011, 002:3012, 003:7001; M[010]=0005, M[011]=0007; pulse RUN → HALTED after 21 cycles; AC=000C; E=0; PRG_RDATA@012=000C; PC=004.
- ADD carry: AC=FFFF plus M=0001 → AC=0000, E=1. CIL on 8001 with E=0 → AC=0002, E=1.
- ISZ on M[020]=FFFF → M[020]=0000, next instruction skipped (PC+2), instruction takes 7 cycles. Indirect LDA via M[030]=0020 → AC=M[020].
- I/O: pulse IN_VALID with 0x41 → IN_READY=0; SKI skips; INP → AC[7:0]=41, IN_READY=1. OUT → OUT_VALID=1, OUT_DATA=41; hold OUT_ACK=0 → SKO does not skip; OUT_ACK → OUT_VALID=0.
- Interrupt: ION, FGO=1, PC=005 → interrupt cycle gives M[000]=0005 (PC value saved), PC=001, IEN=0, t=0.
- RST_N low at t=4 of STA → all outputs reset, memory unchanged, no write. PRG_WE while running is ignored. DATA_W=20 build → LDA/ADD test passes with ADDR_W=16.

Source files
------------

// File: rtl/mano_core_p.sv
// Parametrised Mano basic computer: internal word-addressed memory, host program
// load/readback, run/halt control, interrupt cycle and handshaked 8-bit I/O flags.
module mano_core_p #(
  parameter int DATA_W = 16,
  parameter bit INT_EN_RST = 1'b0,
  localparam int ADDR_W = DATA_W - 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RUN,
  output logic              HALTED,
  input  logic              PRG_WE,
  input  logic [ADDR_W-1:0] PRG_ADDR,
  input  logic [DATA_W-1:0] PRG_DATA,
  output logic [DATA_W-1:0] PRG_RDATA,
  input  logic [7:0]        IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [7:0]        OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_ACK,
  output logic [ADDR_W-1:0] Q_PC,
  output logic [ADDR_W-1:0] Q_AR,
  output logic [DATA_W-1:0] Q_IR,
  output logic [DATA_W-1:0] Q_DR,
  output logic [DATA_W-1:0] AC,
  output logic              E,
  output logic [2:0]        t
);

  typedef enum logic [2:0] {
    OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3,
    OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_REG = 3'd7
  } opcode_e;

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
  logic [DATA_W-1:0] ir_q, ir_d, dr_q, dr_d, ac_q, ac_d, tr_q, tr_d;
  logic [2:0]        sc_q, sc_d;
  logic              e_q, e_d, i_q, i_d, s_q, s_d, r_q, r_d, ien_q, ien_d;
  logic              fgi_q, fgi_d, fgo_q, fgo_d;
  logic [7:0]        inpr_q, inpr_d, outr_q, outr_d;

  logic [DATA_W-1:0] mem_rd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  opcode_e           op;

  assign mem_rd = mem[ar_q];
  assign op     = opcode_e'(ir_q[DATA_W-2:DATA_W-4]);

  always_comb begin
    pc_d = pc_q; ar_d = ar_q; ir_d = ir_q; dr_d = dr_q; ac_d = ac_q; tr_d = tr_q;
    e_d = e_q; sc_d = sc_q; i_d = i_q; s_d = s_q; r_d = r_q; ien_d = ien_q;
    fgi_d = fgi_q; fgo_d = fgo_q; inpr_d = inpr_q; outr_d = outr_q;
    mem_we = 1'b0;
    mem_wdata = ac_q;

    // Device-side flag events; instruction clears below override them.
    if (IN_VALID && !fgi_q) begin
      inpr_d = IN_DATA;
      fgi_d  = 1'b1;
    end
    if (OUT_ACK && !fgo_q) fgo_d = 1'b1;

    if (!s_q) begin
      if (RUN) begin
        s_d  = 1'b1;
        sc_d = 3'd0;
      end
    end else begin
      sc_d = sc_q + 3'd1;
      if (ien_q && (fgi_q || fgo_q) && sc_q > 3'd2) r_d = 1'b1;
      if (r_q && sc_q <= 3'd2) begin
        case (sc_q)
          3'd0: begin
            ar_d = '0;
            tr_d = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
          end
          3'd1: begin
            mem_we    = 1'b1;
            mem_wdata = tr_q;
            pc_d      = '0;
          end
          default: begin
            pc_d  = pc_q + ONE_A;
            ien_d = 1'b0;
            r_d   = 1'b0;
            sc_d  = 3'd0;
          end
        endcase
      end else begin
        case (sc_q)
          3'd0: ar_d = pc_q;
          3'd1: begin
            ir_d = mem_rd;
            pc_d = pc_q + ONE_A;
          end
          3'd2: begin
            ar_d = ir_q[ADDR_W-1:0];
            i_d  = ir_q[DATA_W-1];
          end
          3'd3: begin
            if (op == OP_REG) begin
              sc_d = 3'd0;
              if (!i_q) begin
                if (ir_q[11]) ac_d = '0;
                if (ir_q[10]) e_d = 1'b0;
                if (ir_q[9])  ac_d = ~ac_d;
                if (ir_q[8])  e_d = ~e_d;
                if (ir_q[7])  {e_d, ac_d} = {ac_d[0], e_d, ac_d[DATA_W-1:1]};
                if (ir_q[6])  {e_d, ac_d} = {ac_d, e_d};
                if (ir_q[5])  ac_d = ac_d + ONE_D;
                if ((ir_q[4] && !ac_q[DATA_W-1]) || (ir_q[3] && ac_q[DATA_W-1]) ||
                    (ir_q[2] && ac_q == '0) || (ir_q[1] && !e_q))
                  pc_d = pc_q + ONE_A;
                if (ir_q[0]) s_d = 1'b0;
              end else begin
                if (ir_q[11]) begin
                  ac_d[7:0] = inpr_q;
                  fgi_d     = 1'b0;
                end
                if (ir_q[10]) begin
                  outr_d = ac_q[7:0];
                  fgo_d  = 1'b0;
                end
                if ((ir_q[9] && fgi_q) || (ir_q[8] && fgo_q)) pc_d = pc_q + ONE_A;
                if (ir_q[7]) ien_d = 1'b1;
                if (ir_q[6]) ien_d = 1'b0;
              end
            end else if (i_q) begin
              ar_d = mem_rd[ADDR_W-1:0];
            end
          end
          default: begin
            case (op)
              OP_AND, OP_ADD, OP_LDA: begin
                if (sc_q == 3'd4) begin
                  dr_d = mem_rd;
                end else begin
                  sc_d = 3'd0;
                  if (op == OP_AND)      ac_d = ac_q & dr_q;
                  else if (op == OP_ADD) {e_d, ac_d} = {1'b0, ac_q} + {1'b0, dr_q};
                  else                   ac_d = dr_q;
                end
              end
              OP_STA: begin
                mem_we    = 1'b1;
                mem_wdata = ac_q;
                sc_d      = 3'd0;
              end
              OP_BUN: begin
                pc_d = ar_q;
                sc_d = 3'd0;
              end
              OP_BSA: begin
                if (sc_q == 3'd4) begin
                  mem_we    = 1'b1;
                  mem_wdata = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
                  ar_d      = ar_q + ONE_A;
                end else begin
                  pc_d = ar_q;
                  sc_d = 3'd0;
                end
              end
              OP_ISZ: begin
                if (sc_q == 3'd4) begin
                  dr_d = mem_rd;
                end else if (sc_q == 3'd5) begin
                  dr_d = dr_q + ONE_D;
                end else begin
                  mem_we    = 1'b1;
                  mem_wdata = dr_q;
                  if (dr_q == '0) pc_d = pc_q + ONE_A;
                  sc_d = 3'd0;
                end
              end
              default: sc_d = 3'd0;
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q <= '0; ar_q <= '0; ir_q <= '0; dr_q <= '0; ac_q <= '0; tr_q <= '0;
      e_q <= 1'b0; sc_q <= 3'd0; i_q <= 1'b0; s_q <= 1'b0; r_q <= 1'b0;
      ien_q <= INT_EN_RST; fgi_q <= 1'b0; fgo_q <= 1'b1;
      inpr_q <= 8'h00; outr_q <= 8'h00;
    end else begin
      pc_q <= pc_d; ar_q <= ar_d; ir_q <= ir_d; dr_q <= dr_d; ac_q <= ac_d; tr_q <= tr_d;
      e_q <= e_d; sc_q <= sc_d; i_q <= i_d; s_q <= s_d; r_q <= r_d;
      ien_q <= ien_d; fgi_q <= fgi_d; fgo_q <= fgo_d;
      inpr_q <= inpr_d; outr_q <= outr_d;
    end
  end

  // Memory keeps its contents across reset; host writes only land while halted.
  always_ff @(posedge CLK) begin
    if (PRG_WE && !s_q) mem[PRG_ADDR] <= PRG_DATA;
    else if (mem_we)    mem[ar_q] <= mem_wdata;
  end

  assign HALTED    = ~s_q;
  assign PRG_RDATA = mem[PRG_ADDR];
  assign IN_READY  = ~fgi_q;
  assign OUT_DATA  = outr_q;
  assign OUT_VALID = ~fgo_q;
  assign Q_PC      = pc_q;
  assign Q_AR      = ar_q;
  assign Q_IR      = ir_q;
  assign Q_DR      = dr_q;
  assign AC        = ac_q;
  assign E         = e_q;
  assign t         = sc_q;

endmodule

// File: tb/tb_mano_core_p.sv
// Directed bench for mano_core_p: a 16-bit core exercised by small programs,
// plus a 20-bit build running a short LDA/ADD program.
module tb_mano_core_p;

  logic        CLK;
  logic        RST_N, RUN, PRG_WE, IN_VALID, OUT_ACK;
  logic [11:0] PRG_ADDR;
  logic [15:0] PRG_DATA;
  logic [7:0]  IN_DATA;
  logic        HALTED, IN_READY, OUT_VALID, E;
  logic [15:0] PRG_RDATA, Q_IR, Q_DR, AC;
  logic [11:0] Q_PC, Q_AR;
  logic [7:0]  OUT_DATA;
  logic [2:0]  t;

  logic        rst_n_w, run_w, prg_we_w, in_valid_w, out_ack_w;
  logic [15:0] prg_addr_w;
  logic [19:0] prg_data_w;
  logic [7:0]  in_data_w;
  logic        halted_w, in_ready_w, out_valid_w, e_w;
  logic [19:0] prg_rdata_w, ir_w, dr_w, ac_w;
  logic [15:0] pc_w, ar_w;
  logic [7:0]  out_data_w;
  logic [2:0]  t_w;

  int tests_run;
  int tests_failed;

  mano_core_p dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .HALTED(HALTED),
    .PRG_WE(PRG_WE), .PRG_ADDR(PRG_ADDR), .PRG_DATA(PRG_DATA), .PRG_RDATA(PRG_RDATA),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_ACK(OUT_ACK),
    .Q_PC(Q_PC), .Q_AR(Q_AR), .Q_IR(Q_IR), .Q_DR(Q_DR), .AC(AC), .E(E), .t(t)
  );

  mano_core_p #(.DATA_W(20)) dut20 (
    .CLK(CLK), .RST_N(rst_n_w), .RUN(run_w), .HALTED(halted_w),
    .PRG_WE(prg_we_w), .PRG_ADDR(prg_addr_w), .PRG_DATA(prg_data_w), .PRG_RDATA(prg_rdata_w),
    .IN_DATA(in_data_w), .IN_VALID(in_valid_w), .IN_READY(in_ready_w),
    .OUT_DATA(out_data_w), .OUT_VALID(out_valid_w), .OUT_ACK(out_ack_w),
    .Q_PC(pc_w), .Q_AR(ar_w), .Q_IR(ir_w), .Q_DR(dr_w), .AC(ac_w), .E(e_w), .t(t_w)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset;
    RST_N = 1'b0; RUN = 1'b0; PRG_WE = 1'b0; IN_VALID = 1'b0; OUT_ACK = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic load(input logic [11:0] a, input logic [15:0] d);
    PRG_ADDR = a; PRG_DATA = d; PRG_WE = 1'b1;
    @(negedge CLK);
    PRG_WE = 1'b0;
  endtask

  task automatic peek(input logic [11:0] a, output logic [15:0] d);
    PRG_ADDR = a;
    #1;
    d = PRG_RDATA;
  endtask

  task automatic start_run;
    RUN = 1'b1;
    @(negedge CLK);
    RUN = 1'b0;
  endtask

  task automatic wait_halt(input int limit, output int n);
    n = 0;
    while (!HALTED && n < limit) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic test_reset;
    do_reset;
    tests_run++;
    if ({Q_PC, Q_AR, Q_IR, Q_DR, AC} !== 72'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs: got pc=%h ar=%h ir=%h dr=%h ac=%h, expected all zero", Q_PC, Q_AR, Q_IR, Q_DR, AC);
    end
    tests_run++;
    if ({HALTED, IN_READY, OUT_VALID, E, t, OUT_DATA} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00}) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got halted=%b in_ready=%b out_valid=%b e=%b t=%0d out=%h, expected 1 1 0 0 0 00",
               HALTED, IN_READY, OUT_VALID, E, t, OUT_DATA);
    end
  endtask

  task automatic test_basic;
    int n;
    logic [15:0] d;
    do_reset;
    load(12'h000, 16'h2010); load(12'h001, 16'h1011); load(12'h002, 16'h3012);
    load(12'h003, 16'h7001); load(12'h010, 16'h0005); load(12'h011, 16'h0007);
    start_run;
    wait_halt(100, n);
    tests_run++;
    if (n !== 21) begin tests_failed++; $display("[TB] FAIL basic_cycles: got %0d expected 21", n); end
    tests_run++;
    if (AC !== 16'h000C || E !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL basic_ac: got ac=%h e=%b expected ac=000c e=0", AC, E);
    end
    tests_run++;
    if (Q_PC !== 12'h004) begin tests_failed++; $display("[TB] FAIL basic_pc: got %h expected 004", Q_PC); end
    peek(12'h012, d);
    tests_run++;
    if (d !== 16'h000C) begin tests_failed++; $display("[TB] FAIL basic_sta: got M[012]=%h expected 000c", d); end
  endtask

  task automatic test_add_carry;
    int n;
    do_reset;
    load(12'h000, 16'h2010); load(12'h001, 16'h1011); load(12'h002, 16'h7001);
    load(12'h010, 16'hFFFF); load(12'h011, 16'h0001);
    start_run;
    wait_halt(100, n);
    tests_run++;
    if (AC !== 16'h0000 || E !== 1'b1 || n !== 16) begin
      tests_failed++; $display("[TB] FAIL add_carry: got ac=%h e=%b cycles=%0d expected ac=0000 e=1 cycles=16", AC, E, n);
    end
  endtask

  task automatic test_cil;
    int n;
    do_reset;
    load(12'h000, 16'h2010); load(12'h001, 16'h7400); load(12'h002, 16'h7040);
    load(12'h003, 16'h7001); load(12'h010, 16'h8001);
    start_run;
    wait_halt(100, n);
    tests_run++;
    if (AC !== 16'h0002 || E !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL cil: got ac=%h e=%b expected ac=0002 e=1", AC, E);
    end
  endtask

  task automatic test_isz;
    int n;
    logic [15:0] d;
    do_reset;
    load(12'h000, 16'h6020); load(12'h001, 16'h7001); load(12'h002, 16'h7001);
    load(12'h020, 16'hFFFF);
    start_run;
    wait_halt(100, n);
    tests_run++;
    if (n !== 11) begin tests_failed++; $display("[TB] FAIL isz_cycles: got %0d expected 11", n); end
    tests_run++;
    if (Q_PC !== 12'h003) begin tests_failed++; $display("[TB] FAIL isz_skip: got pc=%h expected 003", Q_PC); end
    peek(12'h020, d);
    tests_run++;
    if (d !== 16'h0000) begin tests_failed++; $display("[TB] FAIL isz_mem: got M[020]=%h expected 0000", d); end
  endtask

  task automatic test_indirect;
    int n;
    do_reset;
    load(12'h000, 16'hA030); load(12'h001, 16'h7001);
    load(12'h020, 16'h1234); load(12'h030, 16'h0020);
    start_run;
    wait_halt(100, n);
    tests_run++;
    if (AC !== 16'h1234 || n !== 10) begin
      tests_failed++; $display("[TB] FAIL indirect_lda: got ac=%h cycles=%0d expected ac=1234 cycles=10", AC, n);
    end
  endtask

  task automatic test_io;
    int n;
    do_reset;
    load(12'h000, 16'hF200); load(12'h001, 16'h4000); load(12'h002, 16'hF800);
    load(12'h003, 16'hF400); load(12'h004, 16'hF100); load(12'h005, 16'h4007);
    load(12'h006, 16'h7001); load(12'h007, 16'hF100); load(12'h008, 16'h4007);
    load(12'h009, 16'h7001);
    start_run;
    repeat (20) @(negedge CLK);
    tests_run++;
    if (IN_READY !== 1'b1 || HALTED !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL io_idle: got in_ready=%b halted=%b expected 1 0", IN_READY, HALTED);
    end
    IN_DATA = 8'h41; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    tests_run++;
    if (IN_READY !== 1'b0) begin tests_failed++; $display("[TB] FAIL io_fgi_set: got in_ready=%b expected 0", IN_READY); end
    n = 0;
    while (!OUT_VALID && n < 60) begin
      @(negedge CLK);
      n++;
    end
    tests_run++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h41) begin
      tests_failed++; $display("[TB] FAIL io_out: got out_valid=%b out_data=%h expected 1 41", OUT_VALID, OUT_DATA);
    end
    tests_run++;
    if (AC !== 16'h0041 || IN_READY !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL io_inp: got ac=%h in_ready=%b expected 0041 1", AC, IN_READY);
    end
    repeat (30) @(negedge CLK);
    tests_run++;
    if (HALTED !== 1'b0 || OUT_VALID !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL io_sko_wait: got halted=%b out_valid=%b expected 0 1", HALTED, OUT_VALID);
    end
    OUT_ACK = 1'b1;
    @(negedge CLK);
    OUT_ACK = 1'b0;
    tests_run++;
    if (OUT_VALID !== 1'b0) begin tests_failed++; $display("[TB] FAIL io_ack: got out_valid=%b expected 0", OUT_VALID); end
    wait_halt(60, n);
    tests_run++;
    if (HALTED !== 1'b1 || Q_PC !== 12'h00A) begin
      tests_failed++; $display("[TB] FAIL io_sko_skip: got halted=%b pc=%h expected 1 00a", HALTED, Q_PC);
    end
  endtask

  task automatic test_interrupt;
    int n;
    logic [15:0] d;
    do_reset;
    load(12'h000, 16'h4003); load(12'h001, 16'h7001); load(12'h002, 16'h7001);
    load(12'h003, 16'hF080); load(12'h004, 16'h7800);
    start_run;
    repeat (16) @(negedge CLK);
    tests_run++;
    if (Q_PC !== 12'h001 || t !== 3'd0 || Q_AR !== 12'h000 || HALTED !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL int_cycle: got pc=%h t=%0d ar=%h halted=%b expected 001 0 000 0", Q_PC, t, Q_AR, HALTED);
    end
    wait_halt(60, n);
    tests_run++;
    if (Q_PC !== 12'h002) begin tests_failed++; $display("[TB] FAIL int_isr: got pc=%h expected 002", Q_PC); end
    peek(12'h000, d);
    tests_run++;
    if (d !== 16'h0005) begin tests_failed++; $display("[TB] FAIL int_save: got M[000]=%h expected 0005", d); end
  endtask

  task automatic test_reset_mid_sta;
    logic [15:0] d;
    do_reset;
    load(12'h000, 16'h2011); load(12'h001, 16'h3010); load(12'h002, 16'h7001);
    load(12'h010, 16'hABCD); load(12'h011, 16'h1234);
    start_run;
    repeat (10) @(negedge CLK);
    tests_run++;
    if (t !== 3'd4 || Q_AR !== 12'h010 || AC !== 16'h1234) begin
      tests_failed++; $display("[TB] FAIL sta_t4: got t=%0d ar=%h ac=%h expected 4 010 1234", t, Q_AR, AC);
    end
    RST_N = 1'b0;
    #1;
    tests_run++;
    if ({Q_PC, Q_AR, Q_IR, AC, t, HALTED} !== {12'h0, 12'h0, 16'h0, 16'h0, 3'd0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got pc=%h ar=%h ir=%h ac=%h t=%0d halted=%b expected zeros and halted", Q_PC, Q_AR, Q_IR, AC, t, HALTED);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    peek(12'h010, d);
    tests_run++;
    if (d !== 16'hABCD) begin tests_failed++; $display("[TB] FAIL reset_no_write: got M[010]=%h expected abcd", d); end
  endtask

  task automatic test_prg_we_running;
    logic [15:0] d;
    do_reset;
    load(12'h000, 16'h4000); load(12'h050, 16'h1111);
    start_run;
    repeat (5) @(negedge CLK);
    PRG_ADDR = 12'h050; PRG_DATA = 16'h5555; PRG_WE = 1'b1;
    @(negedge CLK);
    PRG_WE = 1'b0;
    peek(12'h050, d);
    tests_run++;
    if (d !== 16'h1111 || HALTED !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL prg_we_running: got M[050]=%h halted=%b expected 1111 0", d, HALTED);
    end
    do_reset;
  endtask

  task automatic load20(input logic [15:0] a, input logic [19:0] d);
    prg_addr_w = a; prg_data_w = d; prg_we_w = 1'b1;
    @(negedge CLK);
    prg_we_w = 1'b0;
  endtask

  task automatic test_width20;
    int n;
    rst_n_w = 1'b0;
    @(negedge CLK);
    rst_n_w = 1'b1;
    @(negedge CLK);
    load20(16'h0000, 20'h20010); load20(16'h0001, 20'h10011); load20(16'h0002, 20'h70001);
    load20(16'h0010, 20'h80005); load20(16'h0011, 20'h80007);
    run_w = 1'b1;
    @(negedge CLK);
    run_w = 1'b0;
    n = 0;
    while (!halted_w && n < 100) begin
      @(negedge CLK);
      n++;
    end
    tests_run++;
    if (ac_w !== 20'h0000C || e_w !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL w20_add: got ac=%h e=%b expected 0000c 1", ac_w, e_w);
    end
    tests_run++;
    if (pc_w !== 16'h0003 || n !== 16) begin
      tests_failed++; $display("[TB] FAIL w20_run: got pc=%h cycles=%0d expected 0003 16", pc_w, n);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    RST_N = 1'b0; RUN = 1'b0; PRG_WE = 1'b0; PRG_ADDR = '0; PRG_DATA = '0;
    IN_DATA = 8'h00; IN_VALID = 1'b0; OUT_ACK = 1'b0;
    rst_n_w = 1'b0; run_w = 1'b0; prg_we_w = 1'b0; prg_addr_w = '0; prg_data_w = '0;
    in_data_w = 8'h00; in_valid_w = 1'b0; out_ack_w = 1'b0;
    test_reset;
    test_basic;
    test_add_carry;
    test_cil;
    test_isz;
    test_indirect;
    test_io;
    test_interrupt;
    test_reset_mid_sta;
    test_prg_we_running;
    test_width20;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
